// File: rtl/axi_lite_stream_bridge_pkg.sv
// Shared response codes, FSM state encodings and range helper for the AXI-Lite stream bridge.
package axi_lite_stream_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rd_state_t;

  // Compared at full width so high address bits can never alias into range.
  function automatic logic out_of_range(input logic [63:0] idx, input int unsigned words);
    return idx >= 64'(words);
  endfunction

endpackage

// File: rtl/axi_lite_stream_bridge_hold_reg.sv
// One-entry capture register with full flag; holds an AXI channel beat until the FSM consumes it.
module axi_lite_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk_sys,
  input  logic         rst_b,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      q    <= '0;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_stream_bridge.sv
// AXI4-Lite slave front end: AW/W/B mapped to a write-command stream, AR/R to read-address/read-data streams.
//
// state   | meaning
// W_IDLE  | collecting AW and W beats in either order
// W_ISSUE | write command presented downstream, waiting for wr_ready
// W_RESP  | B response presented, waiting for bready
// R_IDLE  | accepting AR
// R_ISSUE | read index presented downstream, waiting for rd_addr_ready
// R_WAIT  | waiting for rd_data_valid
// R_RESP  | R response presented, waiting for rready
module axi_lite_stream_bridge
  import axi_lite_stream_bridge_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 11,
  parameter int WORD_AW   = 9,
  parameter int MEM_WORDS = 512
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [WORD_AW-1:0]    wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_strb,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [WORD_AW-1:0]    rd_addr,
  output logic                  rd_addr_valid,
  input  logic                  rd_addr_ready,
  input  logic [DATA_W-1:0]     rd_data,
  input  logic                  rd_data_valid
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = $clog2(BYTES);

  // Async assert, release synchronised to s_axi_aclk.
  logic [1:0] rst_pipe;
  logic       rst_n;
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) rst_pipe <= 2'b00;
    else                rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic                  aw_full, w_full;
  logic [ADDR_W-1:0]     aw_q;
  logic [DATA_W+BYTES-1:0] w_q;
  logic                  aw_fire, w_fire, b_fire;
  logic [ADDR_W-1:0]     aw_addr_cur, aw_idx, ar_idx;
  logic [DATA_W-1:0]     w_data_cur;
  logic [BYTES-1:0]      w_strb_cur;

  assign s_axi_awready = rst_n && (wr_state == W_IDLE) && !aw_full;
  assign s_axi_wready  = rst_n && (wr_state == W_IDLE) && !w_full;
  assign s_axi_arready = rst_n && (rd_state == R_IDLE);

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid && s_axi_wready;
  assign b_fire  = s_axi_bvalid && s_axi_bready;

  axi_lite_hold_reg #(.W(ADDR_W)) u_aw_hold (
    .clk_sys (s_axi_aclk),
    .rst_b   (rst_n),
    .load    (aw_fire),
    .clear   (b_fire),
    .d       (s_axi_awaddr),
    .q       (aw_q),
    .full    (aw_full)
  );

  axi_lite_hold_reg #(.W(DATA_W + BYTES)) u_w_hold (
    .clk_sys (s_axi_aclk),
    .rst_b   (rst_n),
    .load    (w_fire),
    .clear   (b_fire),
    .d       ({s_axi_wdata, s_axi_wstrb}),
    .q       (w_q),
    .full    (w_full)
  );

  // Bypass the hold registers so a beat arriving this cycle can complete the pair immediately.
  assign aw_addr_cur              = aw_full ? aw_q : s_axi_awaddr;
  assign {w_data_cur, w_strb_cur} = w_full ? w_q : {s_axi_wdata, s_axi_wstrb};
  assign aw_idx                   = aw_addr_cur >> OFF;
  assign ar_idx                   = s_axi_araddr >> OFF;

  always_ff @(posedge s_axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state     <= W_IDLE;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_strb      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      unique case (wr_state)
        W_IDLE: begin
          if ((aw_full || aw_fire) && (w_full || w_fire)) begin
            if (out_of_range(64'(aw_idx), MEM_WORDS)) begin
              s_axi_bresp  <= RESP_SLVERR;
              s_axi_bvalid <= 1'b1;
              wr_state     <= W_RESP;
            end else if (w_strb_cur == '0) begin
              s_axi_bresp  <= RESP_OKAY;
              s_axi_bvalid <= 1'b1;
              wr_state     <= W_RESP;
            end else begin
              wr_addr  <= WORD_AW'(aw_idx);
              wr_data  <= w_data_cur;
              wr_strb  <= w_strb_cur;
              wr_valid <= 1'b1;
              wr_state <= W_ISSUE;
            end
          end
        end
        W_ISSUE: begin
          if (wr_ready) begin
            wr_valid     <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_bvalid <= 1'b1;
            wr_state     <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            wr_state     <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state      <= R_IDLE;
      rd_addr       <= '0;
      rd_addr_valid <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rvalid  <= 1'b0;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            if (out_of_range(64'(ar_idx), MEM_WORDS)) begin
              s_axi_rdata  <= '0;
              s_axi_rresp  <= RESP_SLVERR;
              s_axi_rvalid <= 1'b1;
              rd_state     <= R_RESP;
            end else begin
              rd_addr       <= WORD_AW'(ar_idx);
              rd_addr_valid <= 1'b1;
              rd_state      <= R_ISSUE;
            end
          end
        end
        R_ISSUE: begin
          if (rd_addr_ready) begin
            rd_addr_valid <= 1'b0;
            rd_state      <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_data_valid) begin
            s_axi_rdata  <= rd_data;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b1;
            rd_state     <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            rd_state     <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule
